// File: rtl/vadd_pkg.sv
// rtl/vadd_pkg.sv - shared FSM state, half-float constants and VLEN default for vadd_seq
package vadd_pkg;

  localparam int VLEN_DEF = 8;

  localparam logic [15:0] HF_INF  = 16'h7C00;
  localparam logic [14:0] HF_MAXF = 15'h7BFF;
  localparam logic [15:0] HF_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } vadd_state_t;

endpackage

// File: rtl/vadd_seq_addp.sv
// rtl/vadd_seq_addp.sv - VADDp two-stage half-precision adder (align/add, register, normalize/round)
module VADDp
  import vadd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum,
  output logic        o_ovf
);

  // Stage 1 signals: operand classification, swap, alignment and add
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_swap, w_sub, w_nan, w_inf;
  logic [15:0] w_x, w_y;
  logic [4:0]  w_ex, w_ey, w_d;
  logic [10:0] w_mx, w_my;
  logic [13:0] w_xe, w_ye, w_ys, w_ys_s;
  logic        w_lost;
  logic [14:0] w_raw;

  // Pipeline register between the two stages
  logic        r_sign, r_nan, r_inf;
  logic [4:0]  r_exp;
  logic [14:0] r_raw;

  // Stage 2 signals: normalize, round, pack
  logic [14:0] w_m;
  logic [5:0]  w_e;
  logic [11:0] w_mr;
  logic        w_g, w_st, w_of;
  logic [15:0] w_out;

  assign w_a_inf = (i_a[14:10] == 5'h1F) && (i_a[9:0] == 10'd0);
  assign w_b_inf = (i_b[14:10] == 5'h1F) && (i_b[9:0] == 10'd0);
  assign w_a_nan = (i_a[14:10] == 5'h1F) && (i_a[9:0] != 10'd0);
  assign w_b_nan = (i_b[14:10] == 5'h1F) && (i_b[9:0] != 10'd0);
  assign w_nan   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (i_a[15] ^ i_b[15]));
  assign w_inf   = w_a_inf | w_b_inf;

  // Larger magnitude goes to x so the aligned difference is never negative
  assign w_swap = i_b[14:0] > i_a[14:0];
  assign w_x    = w_swap ? i_b : i_a;
  assign w_y    = w_swap ? i_a : i_b;
  assign w_sub  = w_x[15] ^ w_y[15];

  // Subnormals use exponent 1 with no hidden bit
  assign w_ex = (w_x[14:10] == 5'd0) ? 5'd1 : w_x[14:10];
  assign w_ey = (w_y[14:10] == 5'd0) ? 5'd1 : w_y[14:10];
  assign w_mx = {(w_x[14:10] != 5'd0), w_x[9:0]};
  assign w_my = {(w_y[14:10] != 5'd0), w_y[9:0]};
  assign w_d  = w_ex - w_ey;

  // Three extra bits (guard, round, sticky) below the mantissa
  assign w_xe   = {w_mx, 3'b000};
  assign w_ye   = {w_my, 3'b000};
  assign w_ys   = (w_d > 5'd13) ? 14'd0 : (w_ye >> w_d);
  assign w_lost = (w_d > 5'd13) ? (w_ye != 14'd0) : ((w_ye & ~(14'h3FFF << w_d)) != 14'd0);
  assign w_ys_s = {w_ys[13:1], w_ys[0] | w_lost};
  assign w_raw  = w_sub ? ({1'b0, w_xe} - {1'b0, w_ys_s}) : ({1'b0, w_xe} + {1'b0, w_ys_s});

  // Stage register; an exact cancellation yields +0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sign <= 1'b0;
      r_nan  <= 1'b0;
      r_inf  <= 1'b0;
      r_exp  <= 5'd0;
      r_raw  <= 15'd0;
    end else begin
      r_sign <= (w_sub && (w_raw == 15'd0)) ? 1'b0 : w_x[15];
      r_nan  <= w_nan;
      r_inf  <= w_inf;
      r_exp  <= w_ex;
      r_raw  <= w_raw;
    end
  end

  // Normalize, round to nearest even, detect overflow and pack the result
  always_comb begin
    w_m   = r_raw;
    w_e   = {1'b0, r_exp};
    w_g   = 1'b0;
    w_st  = 1'b0;
    w_mr  = 12'd0;
    w_of  = 1'b0;
    w_out = 16'd0;
    if (w_m[14]) begin
      w_m = {1'b0, w_m[14:2], w_m[1] | w_m[0]};
      w_e = w_e + 6'd1;
    end else begin
      for (int k = 0; k < 13; k++) begin
        if (!w_m[13] && (w_e > 6'd1)) begin
          w_m = {w_m[13:0], 1'b0};
          w_e = w_e - 6'd1;
        end
      end
    end
    w_g  = w_m[2];
    w_st = w_m[1] | w_m[0];
    w_mr = {1'b0, w_m[13:3]} + {11'd0, w_g & (w_st | w_m[3])};
    if (w_mr[11]) begin
      w_mr = {1'b0, w_mr[11:1]};
      w_e  = w_e + 6'd1;
    end
    w_of = (w_e >= 6'd31);
    if (r_nan)
      w_out = HF_QNAN;
    else if (r_inf || w_of)
      w_out = {r_sign, HF_INF[14:0]};
    else
      w_out = {r_sign, (w_mr[10] ? w_e[4:0] : 5'd0), w_mr[9:0]};
  end

  assign o_sum = w_out;
  assign o_ovf = w_of & ~r_nan & ~r_inf;

endmodule

// File: rtl/vadd_seq.sv
// rtl/vadd_seq.sv - sequential half-float vector add; define VADD_SAT_EN to saturate overflows
module vadd_seq
  import vadd_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int DW   = 16
) (
  input  logic                     Clk2,
  input  logic                     Rst_n,
  input  logic                     Start,
  input  logic [$clog2(VLEN):0]    Len,
  input  logic                     Abort,
  output logic [$clog2(VLEN)-1:0]  RdAddr,
  input  logic [DW-1:0]            RdA,
  input  logic [DW-1:0]            RdB,
  output logic                     WrEn,
  output logic [$clog2(VLEN)-1:0]  WrAddr,
  output logic [DW-1:0]            WrData,
  output logic                     Busy,
  output logic                     Done,
  output logic                     OvfFlag,
  output logic [$clog2(VLEN)-1:0]  OvfIdx
);

  localparam int          AW        = $clog2(VLEN);
  localparam int unsigned LEN_MAX_I = VLEN;
  localparam logic [AW:0] LEN_MAX   = LEN_MAX_I[AW:0];

  vadd_state_t    r_state, w_next;
  logic [AW-1:0]  r_idx, r_last, r_waddr, r_ovf_idx;
  logic           r_vld, r_ovf;
  logic           w_accept;
  logic [AW:0]    w_len_c;
  logic [AW-1:0]  w_last;
  logic [15:0]    w_sum;
  logic           w_ovf;
  logic [DW-1:0]  w_wdata;

  assign w_len_c = (Len > LEN_MAX) ? LEN_MAX : Len;
  assign w_last  = AW'(w_len_c - 1'b1);

  // State register
  always_ff @(posedge Clk2 or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded outputs; Abort wins in ISSUE/DRAIN
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    RdAddr   = '0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = (Len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        Busy   = 1'b1;
        RdAddr = r_idx;
        if (Abort)                w_next = ST_IDLE;
        else if (r_idx == r_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        Busy   = 1'b1;
        w_next = Abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        Done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Issue index, write tag/valid and sticky overflow tracking
  always_ff @(posedge Clk2 or negedge Rst_n) begin
    if (!Rst_n) begin
      r_idx     <= '0;
      r_last    <= '0;
      r_waddr   <= '0;
      r_vld     <= 1'b0;
      r_ovf     <= 1'b0;
      r_ovf_idx <= '0;
    end else begin
      r_idx <= ((r_state == ST_ISSUE) && (w_next == ST_ISSUE)) ? r_idx + 1'b1 : '0;
      r_vld <= (r_state == ST_ISSUE) && !Abort;
      if (r_state == ST_ISSUE) r_waddr <= r_idx;
      if (w_accept) begin
        r_last    <= w_last;
        r_ovf     <= 1'b0;
        r_ovf_idx <= '0;
      end else if (r_vld && w_ovf && !r_ovf) begin
        r_ovf     <= 1'b1;
        r_ovf_idx <= r_waddr;
      end
    end
  end

  VADDp u_add (
    .i_clk   (Clk2),
    .i_rst_n (Rst_n),
    .i_a     (RdA),
    .i_b     (RdB),
    .o_sum   (w_sum),
    .o_ovf   (w_ovf)
  );

`ifdef VADD_SAT_EN
  assign w_wdata = w_ovf ? {w_sum[15], HF_MAXF} : w_sum;
`else
  assign w_wdata = w_sum;
`endif

  assign WrEn    = r_vld;
  assign WrAddr  = r_waddr;
  assign WrData  = w_wdata;
  assign OvfFlag = r_ovf;
  assign OvfIdx  = r_ovf_idx;

endmodule

// File: tb/tb_vadd_seq.sv
// tb/tb_vadd_seq.sv - scoreboard bench for vadd_seq
module tb_vadd_seq;

  logic        Clk2 = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Len = 4'd0;
  logic        Abort = 1'b0;
  logic [2:0]  RdAddr;
  logic [15:0] RdA, RdB;
  logic        WrEn;
  logic [2:0]  WrAddr;
  logic [15:0] WrData;
  logic        Busy, Done, OvfFlag;
  logic [2:0]  OvfIdx;

`ifdef VADD_SAT_EN
  localparam logic [15:0] EXP_OVF = 16'h7BFF;
`else
  localparam logic [15:0] EXP_OVF = 16'h7C00;
`endif

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         e;
  logic [15:0] va[8];
  logic [15:0] vb[8];
  logic [15:0] ve[8];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          d0;

  // Hand-computed half-float sums: 1+1, 2+1, 4+2, .5+.5, 3-1, 1+0, -2-2, 10+5
  logic [15:0] ta[8] = '{16'h3C00, 16'h4000, 16'h4400, 16'h3800, 16'h4200, 16'h3C00, 16'hC000, 16'h4900};
  logic [15:0] tb[8] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h3800, 16'hBC00, 16'h0000, 16'hC000, 16'h4500};
  logic [15:0] ts[8] = '{16'h4000, 16'h4200, 16'h4600, 16'h3C00, 16'h4000, 16'h3C00, 16'hC400, 16'h4B80};

  vadd_seq #(.VLEN(8), .DW(16)) dut (
    .Clk2    (Clk2),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Len     (Len),
    .Abort   (Abort),
    .RdAddr  (RdAddr),
    .RdA     (RdA),
    .RdB     (RdB),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .Busy    (Busy),
    .Done    (Done),
    .OvfFlag (OvfFlag),
    .OvfIdx  (OvfIdx)
  );

  assign RdA = va[RdAddr];
  assign RdB = vb[RdAddr];

  always #5 Clk2 = ~Clk2;

  always @(posedge Clk2) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every strobed write must match the oldest expected write, including its cycle
  always @(negedge Clk2) begin
    if (Done) done_cnt++;
    if (WrEn) begin
      if (sb.size() == 0) begin
        check("wr_extra", 32'(WrAddr), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(WrAddr), e.addr);
        check("wr_data", 32'(WrData), 32'(e.data));
        check("wr_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic fill(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    for (int i = 0; i < 8; i++) begin
      va[i] = a; vb[i] = b; ve[i] = s;
    end
  endtask

  // Called just after an edge; the next edge is E0. Returns inside cycle 1.
  task automatic launch(input int len, input int nexp);
    Start = 1'b1;
    Len   = 4'(len);
    @(posedge Clk2); #1;
    Start = 1'b0;
    Len   = 4'd0;
    for (int i = 0; i < nexp; i++)
      sb.push_back('{addr: i, data: ve[i], cyc: cyc + i + 1});
  endtask

  task automatic wait_done(input int exp_cyc, input int k0);
    int  k = k0;
    bit  seen = 1'b0;
    while (!seen && k < k0 + 40) begin
      @(negedge Clk2);
      if (Done) begin
        seen = 1'b1;
        check("done_cyc", k, exp_cyc);
      end else begin
        k++;
      end
    end
    if (!seen) check("done_seen", 0, 1);
    else begin
      @(negedge Clk2);
      check("done_pulse", 32'(Done), 0);
    end
    @(posedge Clk2); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wren"}, 32'(WrEn), 0);
    check({tag, "_wraddr"}, 32'(WrAddr), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_done"}, 32'(Done), 0);
    check({tag, "_ovf"}, 32'(OvfFlag), 0);
    check({tag, "_ovfidx"}, 32'(OvfIdx), 0);
    check({tag, "_rdaddr"}, 32'(RdAddr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    fill(16'h3C00, 16'h3C00, 16'h4000);
    repeat (3) @(posedge Clk2);
    #1;
    check_zero("rst");
    Rst_n = 1'b1;
    @(posedge Clk2); #1;

    // Basic: 1+1 over four elements
    fill(16'h3C00, 16'h3C00, 16'h4000);
    launch(4, 4);
    wait_done(6, 1);
    check("basic_ovf", 32'(OvfFlag), 0);
    check("basic_sb", sb.size(), 0);

    // Cancellation: 1 + -1 = +0, single element
    fill(16'h3C00, 16'hBC00, 16'h0000);
    launch(1, 1);
    wait_done(3, 1);
    check("cancel_sb", sb.size(), 0);

    // Overflow on elements 2 and 3; index of the first one is kept
    fill(16'h7800, 16'h7800, EXP_OVF);
    va[0] = 16'h3C00; vb[0] = 16'h3C00; ve[0] = 16'h4000;
    va[1] = 16'h4000; vb[1] = 16'h3C00; ve[1] = 16'h4200;
    launch(4, 4);
    wait_done(6, 1);
    check("ovf_flag", 32'(OvfFlag), 1);
    check("ovf_idx", 32'(OvfIdx), 2);
    check("ovf_sb", sb.size(), 0);

    // Zero length: Done in cycle 1, no writes, overflow state cleared
    launch(0, 0);
    check("zero_ovf_clr", 32'(OvfFlag), 0);
    wait_done(1, 1);
    check("zero_ovfidx", 32'(OvfIdx), 0);

    // Clamp: Len=15 gives exactly eight writes
    for (int i = 0; i < 8; i++) begin
      va[i] = ta[i]; vb[i] = tb[i]; ve[i] = ts[i];
    end
    launch(15, 8);
    wait_done(10, 1);
    check("clamp_sb", sb.size(), 0);

    // Abort in the second ISSUE cycle: only element 0 written, no Done
    fill(16'h3C00, 16'h3C00, 16'h4000);
    d0 = done_cnt;
    launch(8, 1);
    @(posedge Clk2); #1;
    Abort = 1'b1;
    @(posedge Clk2); #1;
    Abort = 1'b0;
    check("abort_busy", 32'(Busy), 0);
    repeat (12) @(posedge Clk2);
    #1;
    check("abort_nodone", done_cnt, d0);
    check("abort_sb", sb.size(), 0);

    // Start while busy is ignored; running op completes on time
    fill(16'h4400, 16'h4000, 16'h4600);
    launch(4, 4);
    @(posedge Clk2); #1;
    Start = 1'b1; Len = 4'd2;
    @(posedge Clk2); #1;
    Start = 1'b0; Len = 4'd0;
    wait_done(6, 3);
    check("busy_start_sb", sb.size(), 0);
    check("busy_start_idle", 32'(Busy), 0);

    // Reset mid-ISSUE: outputs clear at once, nothing further written
    fill(16'h7800, 16'h7800, EXP_OVF);
    d0 = done_cnt;
    launch(8, 1);
    @(posedge Clk2); #1;
    @(posedge Clk2); #1;
    Rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge Clk2);
    #1;
    Rst_n = 1'b1;
    repeat (12) @(posedge Clk2);
    #1;
    check("midrst_nodone", done_cnt, d0);
    check("midrst_sb", sb.size(), 0);
    check("midrst_idle", 32'(Busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
